// File: rtl/modulation_router.sv
// Modulation router: issues the per-slot phase-modulation input from per-voice
// state (Prev, Mod, 2-sample feedback) and writes operator results back into
// that state when they return RESULT_LATENCY cycles after issue.
module modulation_router #(
  parameter int NUM_VOICES     = 32,
  parameter int VOICE_W        = 5,
  parameter int SAMPLE_W       = 14,
  parameter int RESULT_LATENCY = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Valid,
  input  logic [VOICE_W-1:0]         i_VoiceNum,
  input  logic [2:0]                 i_OperatorNum,
  input  logic [2:0]                 i_SEL,
  input  logic                       i_MREN,
  input  logic                       i_FREN,
  input  logic [2:0]                 i_FeedbackLevel,
  input  logic signed [SAMPLE_W-1:0] i_Result,
  output logic                       o_Valid,
  output logic [VOICE_W-1:0]         o_VoiceNum,
  output logic [2:0]                 o_OperatorNum,
  output logic signed [SAMPLE_W-1:0] o_Modulation
);

  typedef logic signed [SAMPLE_W-1:0] smp_t;

  // Writeback tag travelling alongside the operator datapath
  typedef struct packed {
    logic               vld;
    logic [VOICE_W-1:0] voice;
    logic [2:0]         op;
    logic               mren;
    logic               fren;
  } wb_t;

  // Saturating add: overflow shows as disagreement of the two top bits
  function automatic smp_t sat_add(input smp_t a, input smp_t b);
    logic [SAMPLE_W:0] s;
    s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (s[SAMPLE_W] != s[SAMPLE_W-1])
      return s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return s[SAMPLE_W-1:0];
  endfunction

  smp_t prev_q [NUM_VOICES];
  smp_t prev_d [NUM_VOICES];
  smp_t mod_q  [NUM_VOICES];
  smp_t mod_d  [NUM_VOICES];
  smp_t fb0_q  [NUM_VOICES];
  smp_t fb0_d  [NUM_VOICES];
  smp_t fb1_q  [NUM_VOICES];
  smp_t fb1_d  [NUM_VOICES];

  wb_t  dl_q [RESULT_LATENCY];
  wb_t  dl_d [RESULT_LATENCY];
  wb_t  head;

  logic               vld_q, vld_d;
  logic [VOICE_W-1:0] voice_q, voice_d;
  logic [2:0]         op_q, op_d;
  logic               mren_q, mren_d;
  logic               fren_q, fren_d;
  smp_t               modu_q, modu_d;

  smp_t                     cur_prev, cur_mod, fb_val;
  logic signed [SAMPLE_W:0] fb_sum, fb_shr;
  logic [3:0]               fb_sh;
  logic                     first_op;

  assign head = dl_q[RESULT_LATENCY-1];

  // Apply the returning result to its voice; issue reads these values (forwarding)
  always_comb begin
    prev_d = prev_q;
    mod_d  = mod_q;
    fb0_d  = fb0_q;
    fb1_d  = fb1_q;
    if (head.vld) begin
      prev_d[head.voice] = i_Result;
      if (head.op == 3'd0)
        mod_d[head.voice] = head.mren ? i_Result : '0;
      else if (head.mren)
        mod_d[head.voice] = sat_add(mod_q[head.voice], i_Result);
      if (head.fren) begin
        fb1_d[head.voice] = fb0_q[head.voice];
        fb0_d[head.voice] = i_Result;
      end
    end
  end

  // Issue: select modulation source; op0 never sees last sample's Prev/Mod
  always_comb begin
    cur_prev = prev_d[i_VoiceNum];
    cur_mod  = mod_d[i_VoiceNum];
    fb_sum   = {fb0_d[i_VoiceNum][SAMPLE_W-1], fb0_d[i_VoiceNum]}
             + {fb1_d[i_VoiceNum][SAMPLE_W-1], fb1_d[i_VoiceNum]};
    fb_sh    = 4'd8 - {1'b0, i_FeedbackLevel};
    fb_shr   = fb_sum >>> fb_sh;
    fb_val   = (i_FeedbackLevel == 3'd0) ? '0 : fb_shr[SAMPLE_W-1:0];
    first_op = (i_OperatorNum == 3'd0);
    vld_d    = i_Valid;
    voice_d  = voice_q;
    op_d     = op_q;
    mren_d   = mren_q;
    fren_d   = fren_q;
    modu_d   = modu_q;
    if (i_Valid) begin
      voice_d = i_VoiceNum;
      op_d    = i_OperatorNum;
      mren_d  = i_MREN;
      fren_d  = i_FREN;
      case (i_SEL)
        3'd1:    modu_d = first_op ? '0 : cur_prev;
        3'd2:    modu_d = first_op ? '0 : cur_mod;
        3'd3:    modu_d = first_op ? '0 : sat_add(cur_mod, cur_prev);
        3'd4:    modu_d = fb_val;
        default: modu_d = '0;
      endcase
    end
  end

  // Delay line: tag from the output register, head meets i_Result
  always_comb begin
    dl_d[0] = {vld_q, voice_q, op_q, mren_q, fren_q};
    for (int i = 1; i < RESULT_LATENCY; i++) dl_d[i] = dl_q[i-1];
  end

  // State registers; reset also drops any in-flight writeback
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      vld_q   <= 1'b0;
      voice_q <= '0;
      op_q    <= '0;
      mren_q  <= 1'b0;
      fren_q  <= 1'b0;
      modu_q  <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        prev_q[v] <= '0;
        mod_q[v]  <= '0;
        fb0_q[v]  <= '0;
        fb1_q[v]  <= '0;
      end
      for (int i = 0; i < RESULT_LATENCY; i++) dl_q[i] <= '0;
    end else begin
      vld_q   <= vld_d;
      voice_q <= voice_d;
      op_q    <= op_d;
      mren_q  <= mren_d;
      fren_q  <= fren_d;
      modu_q  <= modu_d;
      prev_q  <= prev_d;
      mod_q   <= mod_d;
      fb0_q   <= fb0_d;
      fb1_q   <= fb1_d;
      dl_q    <= dl_d;
    end
  end

  assign o_Valid       = vld_q;
  assign o_VoiceNum    = voice_q;
  assign o_OperatorNum = op_q;
  assign o_Modulation  = modu_q;

endmodule

// File: tb/tb_modulation_router.sv
// Bench for modulation_router: two instances (latency 8 and latency 31, the
// latter exercising same-cycle writeback/issue) checked against a per-voice
// integer model with a queue of pending operator results.
module tb_modulation_router;
  localparam int NV   = 32;
  localparam int LAT0 = 8;
  localparam int LAT1 = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               vld;
  logic [4:0]         voice;
  logic [2:0]         op, sel, lvl;
  logic               mren, fren;
  logic signed [13:0] res0, res1;
  logic               ov0, ov1;
  logic [4:0]         ovc0, ovc1;
  logic [2:0]         oop0, oop1;
  logic signed [13:0] om0, om1;

  modulation_router #(.NUM_VOICES(NV), .VOICE_W(5), .SAMPLE_W(14), .RESULT_LATENCY(LAT0)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(vld), .i_VoiceNum(voice), .i_OperatorNum(op),
    .i_SEL(sel), .i_MREN(mren), .i_FREN(fren), .i_FeedbackLevel(lvl), .i_Result(res0),
    .o_Valid(ov0), .o_VoiceNum(ovc0), .o_OperatorNum(oop0), .o_Modulation(om0));

  modulation_router #(.NUM_VOICES(NV), .VOICE_W(5), .SAMPLE_W(14), .RESULT_LATENCY(LAT1)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(vld), .i_VoiceNum(voice), .i_OperatorNum(op),
    .i_SEL(sel), .i_MREN(mren), .i_FREN(fren), .i_FeedbackLevel(lvl), .i_Result(res1),
    .o_Valid(ov1), .o_VoiceNum(ovc1), .o_OperatorNum(oop1), .o_Modulation(om1));

  typedef struct {
    int due;
    int voice;
    int op;
    bit mren;
    bit fren;
    int res;
  } pend_t;

  pend_t q0[$];
  pend_t q1[$];
  int m_prev [2][NV];
  int m_mod  [2][NV];
  int m_fb0  [2][NV];
  int m_fb1  [2][NV];
  int exp_vld [2];
  int exp_voice [2];
  int exp_op [2];
  int exp_mod [2];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  function automatic int clamp(input int x);
    if (x > 8191) return 8191;
    if (x < -8192) return -8192;
    return x;
  endfunction

  function automatic void m_wb(input int k, input pend_t e);
    m_prev[k][e.voice] = e.res;
    if (e.op == 0) m_mod[k][e.voice] = e.mren ? e.res : 0;
    else if (e.mren) m_mod[k][e.voice] = clamp(m_mod[k][e.voice] + e.res);
    if (e.fren) begin
      m_fb1[k][e.voice] = m_fb0[k][e.voice];
      m_fb0[k][e.voice] = e.res;
    end
  endfunction

  function automatic int m_issue(input int k, input int vc, input int o, input int s, input int lv);
    case (s)
      1: return (o == 0) ? 0 : m_prev[k][vc];
      2: return (o == 0) ? 0 : m_mod[k][vc];
      3: return (o == 0) ? 0 : clamp(m_mod[k][vc] + m_prev[k][vc]);
      4: return (lv == 0) ? 0 : (m_fb0[k][vc] + m_fb1[k][vc]) >>> (8 - lv);
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input integer obs, input integer expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // One clock: drive slot and due results, advance model, check both instances
  task automatic step(input bit r, input bit v, input int vc, input int o, input int s,
                      input bit mr, input bit fr, input int lv, input int rs);
    pend_t e;
    rst   = r;
    vld   = v;
    voice = 5'(vc);
    op    = 3'(o);
    sel   = 3'(s);
    mren  = mr;
    fren  = fr;
    lvl   = 3'(lv);
    res0  = 14'($urandom);
    res1  = 14'($urandom);
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      res0 = 14'(e.res);
      if (!r) m_wb(0, e);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      res1 = 14'(e.res);
      if (!r) m_wb(1, e);
    end
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NV; i++) begin
          m_prev[k][i] = 0; m_mod[k][i] = 0; m_fb0[k][i] = 0; m_fb1[k][i] = 0;
        end
        exp_vld[k] = 0; exp_voice[k] = 0; exp_op[k] = 0; exp_mod[k] = 0;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_vld[k] = v ? 1 : 0;
        if (v) begin
          exp_mod[k]   = m_issue(k, vc, o, s, lv);
          exp_voice[k] = vc;
          exp_op[k]    = o;
        end
      end
      if (v) begin
        q0.push_back('{cyc + 1 + LAT0, vc, o, mr, fr, rs});
        q1.push_back('{cyc + 1 + LAT1, vc, o, mr, fr, rs});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("i0_valid", ov0, exp_vld[0]);
    chk("i0_voice", ovc0, exp_voice[0]);
    chk("i0_op", oop0, exp_op[0]);
    chk("i0_mod", om0, exp_mod[0]);
    chk("i1_valid", ov1, exp_vld[1]);
    chk("i1_voice", ovc1, exp_voice[1]);
    chk("i1_op", oop1, exp_op[1]);
    chk("i1_mod", om1, exp_mod[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; voice = '0; op = '0; sel = '0; lvl = '0;
    mren = 1'b0; fren = 1'b0; res0 = '0; res1 = '0;

    // Reset held two cycles with valid high
    step(1, 1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0, 0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_mod", om0, 0);
    step(0, 1, 0, 1, 1, 0, 0, 0, 0);
    chk("post_rst_sel1", om0, 0);
    idle(35);

    // Voice 3: Prev reaches op1, op0 ignores it
    step(0, 1, 3, 0, 0, 0, 0, 0, 100);
    idle(35);
    step(0, 1, 3, 1, 1, 0, 0, 0, 11);
    chk("v3_op1_prev_i0", om0, 100);
    chk("v3_op1_prev_i1", om1, 100);
    step(0, 1, 3, 0, 1, 0, 0, 0, 12);
    chk("v3_op0_prev", om0, 0);

    // Voice 5: modulation sum saturates both ways
    step(0, 1, 5, 0, 0, 1, 0, 0, 8000);
    step(0, 1, 5, 1, 0, 1, 0, 0, 8000);
    idle(35);
    step(0, 1, 5, 2, 2, 0, 0, 0, 0);
    chk("v5_sat_pos", om0, 8191);
    step(0, 1, 5, 0, 0, 1, 0, 0, -8000);
    step(0, 1, 5, 1, 0, 1, 0, 0, -8000);
    idle(35);
    step(0, 1, 5, 2, 2, 0, 0, 0, 0);
    chk("v5_sat_neg", om1, -8192);

    // Voice 7: feedback history at levels 7, 4, 0
    step(0, 1, 7, 0, 0, 0, 1, 0, 400);
    step(0, 1, 7, 1, 0, 0, 1, 0, 600);
    idle(35);
    step(0, 1, 7, 2, 4, 0, 0, 7, 0);
    chk("v7_fb_l7", om0, 500);
    step(0, 1, 7, 2, 4, 0, 0, 4, 0);
    chk("v7_fb_l4", om0, 62);
    step(0, 1, 7, 2, 4, 0, 0, 0, 0);
    chk("v7_fb_l0", om1, 0);
    idle(35);

    // Voice 9: writeback and issue in the same cycle on the latency-31 instance
    step(0, 1, 9, 0, 0, 0, 0, 0, 77);
    idle(LAT1);
    step(0, 1, 9, 1, 1, 0, 0, 0, 0);
    chk("v9_forward_i1", om1, 77);
    chk("v9_prev_i0", om0, 77);

    // Reset with three results in flight
    step(0, 1, 10, 0, 0, 1, 1, 0, 300);
    step(0, 1, 11, 0, 0, 1, 1, 0, 301);
    step(0, 1, 12, 0, 0, 1, 1, 0, 302);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(35);
    step(0, 1, 10, 1, 1, 0, 0, 0, 0);
    chk("flush_v10_i0", om0, 0);
    chk("flush_v10_i1", om1, 0);
    step(0, 1, 11, 1, 1, 0, 0, 0, 0);
    chk("flush_v11", om0, 0);
    step(0, 1, 12, 1, 1, 0, 0, 0, 0);
    chk("flush_v12", om1, 0);

    // Random slots, occasional reset
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, NV - 1), $urandom_range(0, 5), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           int'($urandom_range(0, 16383)) - 8192);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
